// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receive deserializer: synchronises RxD, validates start/stop bits, emits bytes LSB-first.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point (+1 cycle latency).
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_idle,
  output logic       framing_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] FULL_TAP = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // Vote is complete one cycle after the nominal start instant.
  localparam logic [CW-1:0] START_TAP = CW'(CLKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0] START_TAP = CW'(CLKS_PER_BIT / 2 - 1);
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic          bit_s;

  logic [2:0]    state,     state_nxt;
  logic [CW-1:0] cnt,       cnt_nxt;
  logic [2:0]    idx,       idx_nxt;
  logic [7:0]    shreg,     shreg_nxt;
  logic [7:0]    data_nxt;
  logic          ready_nxt;
  logic          ferr_nxt;
  logic          idle_nxt;

  // Two-flop synchroniser; idle-high reset value avoids a false start after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_d1;
  logic rx_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign bit_s = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign bit_s = rx_s;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      RxD_data       <= '0;
      RxD_data_ready <= 1'b0;
      framing_err    <= 1'b0;
      RxD_idle       <= 1'b1;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      idx            <= idx_nxt;
      shreg          <= shreg_nxt;
      RxD_data       <= data_nxt;
      RxD_data_ready <= ready_nxt;
      framing_err    <= ferr_nxt;
      RxD_idle       <= idle_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = RxD_data;
    ready_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end
      end

      S_START: begin
        if (cnt == START_TAP) begin
          if (!bit_s) begin
            state_nxt = S_DATA;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt == FULL_TAP) begin
          shreg_nxt[idx] = bit_s;
          cnt_nxt        = '0;
          if (idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt == FULL_TAP) begin
          cnt_nxt = '0;
          if (bit_s) begin
            data_nxt  = shreg;
            ready_nxt = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = S_RECOVER;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      // Hold off until a low break releases, so it is not taken as a new start bit.
      S_RECOVER: begin
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    idle_nxt = (state_nxt == S_IDLE);
  end

endmodule
